instr_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the main decoder. Holds the PC and issues
//  in-order requests to instruction memory via valid/ready, then buffers returned words in a

---
 rtl/mips_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcodes and fetch-stage types
// Purpose: opcode constants shared between the fetch stage and the main decoder,
//          plus the fetch FSM state enum and the fetch FIFO entry struct.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [5:0] opcode_of(input logic [FETCH_DATA_W-1:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer between imem responses and decode
// Purpose: DEPTH-entry FIFO of fetch_entry_t. Flush has priority over push and pop.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_entry  write an entry (ignored when full unless popping the same cycle)
//   pop               remove head (ignored when empty)
//   flush             discard all entries
//   head              current head entry (contents undefined when empty)
//   count/empty/full  occupancy
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage feeding the main decoder
// Purpose: holds the PC, issues in-order imem requests under a credit limit,
//          buffers responses in fetch_fifo and presents them to decode. Execute
//          redirects reload the PC, flush the buffer and drop stale responses.
// Build option: JUMP_PREDECODE_EN - fetch follows j instructions itself.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req_valid/ready/addr       fetch request handshake, addr = pc
//   imem_rsp_valid/data             in-order read data
//   redirect_valid/pc               execute redirect, target bits [1:0] ignored
//   dec_valid/ready                 decode handshake
//   dec_instr/opcode/pc/pcplus4     FIFO head (zero when empty)
module instr_fetch
    import mips_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_instr,
    output logic [5:0]        dec_opcode,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [ADDR_W-1:0] dec_pcplus4
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [CNT_W-1:0]  outstanding, outstanding_nxt;
    logic [CNT_W-1:0]  drop_cnt, drop_nxt;

    logic              accept;
    logic              rsp_live;
    logic              drop_last;
    logic              credit;
    logic              push_ok;
    logic              jump_hit;
    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] rsp_addr;
    logic [ADDR_W-1:0] redirect_target;
    logic              unused_redirect_low;

    fetch_entry_t      push_entry;
    fetch_entry_t      fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_low = &{1'b0, redirect_pc[1:0]};

    // A response with nothing outstanding can only be left over from before a
    // reset; it is ignored rather than corrupting the counters.
    assign rsp_live  = imem_rsp_valid && (outstanding != '0);
    assign drop_last = (state == S_DRAIN) && rsp_live && (drop_cnt == CNT_W'(1));
    assign credit    = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(BUF_DEPTH);

    // The cycle that drops the last stale response may already issue the next fetch.
    assign imem_req_valid = !reset && credit && ((state == S_RUN) || drop_last);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // In S_RUN every outstanding request is live and sequential, ending at pc-4,
    // so the oldest one (the one responding) sits at pc - 4*outstanding.
    assign rsp_addr = pc - ADDR_W'({outstanding, 2'b00});
    assign push_ok  = rsp_live && (state == S_RUN) && !redirect_valid;

`ifdef JUMP_PREDECODE_EN
    logic [ADDR_W-1:0] rsp_pcplus4;
    assign rsp_pcplus4 = rsp_addr + ADDR_W'(4);
    assign jump_hit    = push_ok && (opcode_of(FETCH_DATA_W'(imem_rsp_data)) == OP_J);
    assign jump_pc     = (rsp_pcplus4 & {{(ADDR_W - 28){1'b1}}, 28'd0})
                       | ADDR_W'({imem_rsp_data[25:0], 2'b00});
`else
    assign jump_hit = 1'b0;
    assign jump_pc  = pc;
`endif

    always_comb begin
        outstanding_nxt = outstanding;
        case ({accept, rsp_live})
            2'b10:   outstanding_nxt = outstanding + CNT_W'(1);
            2'b01:   outstanding_nxt = outstanding - CNT_W'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    // Any redirect (external or predecoded jump) makes every request still in
    // flight after this cycle stale, so drop_cnt simply takes that count; this
    // also covers a redirect while already draining without double counting.
    always_comb begin
        pc_nxt    = pc;
        state_nxt = state;
        drop_nxt  = drop_cnt;
        if (accept) begin
            pc_nxt = pc + ADDR_W'(4);
        end
        if (redirect_valid) begin
            pc_nxt    = redirect_target;
            drop_nxt  = outstanding_nxt;
            state_nxt = (outstanding_nxt != '0) ? S_DRAIN : S_RUN;
        end else if (jump_hit) begin
            pc_nxt    = jump_pc;
            drop_nxt  = outstanding_nxt;
            state_nxt = (outstanding_nxt != '0) ? S_DRAIN : S_RUN;
        end else if ((state == S_DRAIN) && rsp_live) begin
            drop_nxt = drop_cnt - CNT_W'(1);
            if (drop_cnt == CNT_W'(1)) begin
                state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_nxt;
        end
    end

    assign push_entry.instr = FETCH_DATA_W'(imem_rsp_data);
    assign push_entry.pc    = FETCH_ADDR_W'(rsp_addr);

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_ok && !fifo_full),
        .push_entry (push_entry),
        .pop        (dec_valid && dec_ready),
        .flush      (redirect_valid),
        .head       (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign dec_valid   = !fifo_empty;
    assign dec_instr   = fifo_empty ? '0 : DATA_W'(fifo_head.instr);
    assign dec_opcode  = dec_instr[31:26];
    assign dec_pc      = fifo_empty ? '0 : ADDR_W'(fifo_head.pc);
    assign dec_pcplus4 = fifo_empty ? '0 : ADDR_W'(fifo_head.pc) + ADDR_W'(4);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [5:0]  dec_opcode;
    logic [31:0] dec_pc;
    logic [31:0] dec_pcplus4;

    instr_fetch #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_opcode     (dec_opcode),
        .dec_pc         (dec_pc),
        .dec_pcplus4    (dec_pcplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_due = 0;
    int          stale   = 0;
    int          cur_lat = 0;
    int          acc_count = 0;
    int          first_dv;
    bit          acc_seen = 0;
    logic [31:0] last_acc_addr = '0;
    logic [31:0] fetch_pc = '0;

    // Program image: a fixed j at 0x10 (target 0x100), everything else a
    // non-jump opcode with address-dependent low bits.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [5:0] op;
        if (a == 32'h10) return 32'h0800_0040;
        case ((a >> 2) % 5)
            0:       op = OP_RTYPE;
            1:       op = OP_LW;
            2:       op = OP_SW;
            3:       op = OP_BEQ;
            default: op = OP_ADDI;
        endcase
        return {op, a[27:2] ^ 26'h15a_5a5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every decode handshake pops the next expected instruction.
    always @(negedge clk) begin
        #2;
        if (!reset && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dec_unexpected: got pc %h expected no instruction", dec_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("dec_pc", dec_pc, mon_e.pc);
                check("dec_instr", dec_instr, mon_e.instr);
                check("dec_opcode", {26'd0, dec_opcode}, {26'd0, mon_e.instr[31:26]});
                check("dec_pcplus4", dec_pcplus4, mon_e.pc + 32'd4);
            end
        end
    end

    // Reference model: program-order fetch pointer plus a count of responses
    // that belong to abandoned paths.
    task automatic model_update();
        logic [31:0] w;
        logic [31:0] nxt;
        bit          jumped;
        int          due;
        if (reset) begin
            exp_q.delete();
            pend_q.delete();
            stale    = 0;
            last_due = cyc;
            fetch_pc = 32'h0;
            return;
        end
        if (imem_rsp_valid) void'(pend_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            acc_count++;
            acc_seen      = 1;
            last_acc_addr = imem_req_addr;
            due = cyc + 1 + cur_lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_q.push_back('{imem_req_addr, due});
        end
        if (redirect_valid) begin
            exp_q.delete();
            fetch_pc = {redirect_pc[31:2], 2'b00};
            stale    = pend_q.size();
        end else if (imem_rsp_valid) begin
            if (stale > 0) begin
                stale--;
            end else begin
                w = mem_word(fetch_pc);
                exp_q.push_back('{fetch_pc, w});
                jumped = 0;
                nxt = fetch_pc + 32'd4;
`ifdef JUMP_PREDECODE_EN
                if (w[31:26] == 6'b000010) begin
                    fetch_pc = {nxt[31:28], w[25:0], 2'b00};
                    stale    = pend_q.size();
                    jumped   = 1;
                end
`endif
                if (!jumped) fetch_pc = nxt;
            end
        end
    endtask

    task automatic step(input bit rst, input bit mrdy, input bit drdy,
                        input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        cyc++;
        reset          = rst;
        imem_req_ready = mrdy;
        dec_ready      = drdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #3;
        model_update();
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
    endtask

    initial begin
        reset = 1'b1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        redirect_valid = 0; redirect_pc = '0; dec_ready = 0;

        // Reset state
        step(1, 1, 1, 0, '0);
        step(1, 1, 1, 0, '0);
        step(1, 1, 1, 0, '0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);

        // Streaming with 1-cycle memory, decode always ready
        cur_lat = 0;
        first_dv = -1;
        for (int i = 1; i <= 24; i++) begin
            step(0, 1, 1, 0, '0);
            if (i == 1) begin
                check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
                check("first_req_addr", imem_req_addr, 32'h0);
                check("first_dec_valid", {31'd0, dec_valid}, 32'd0);
            end
            if (dec_valid && first_dv < 0) first_dv = i;
        end
        check("first_dec_latency", first_dv, 32'd3);

        // Decode stalled: credit stops at two requests
        do_reset();
        acc_count = 0;
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, '0);
        check("stall_accepts", acc_count, 32'd2);
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("stall_dec_valid", {31'd0, dec_valid}, 32'd1);
        acc_seen = 0;
        for (int i = 0; i < 10 && !acc_seen; i++) step(0, 1, 1, 0, '0);
        check("resume_seen", {31'd0, acc_seen}, 32'd1);
        check("resume_addr", last_acc_addr, 32'h8);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, '0);

        // Memory back-pressure: request held with stable address
        do_reset();
        step(0, 1, 1, 0, '0);
        acc_count = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, '0);
            check("hold_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("hold_req_addr", imem_req_addr, 32'h4);
        end
        check("hold_no_accept", acc_count, 32'd0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, '0);

        // Redirect with two fetches in flight
        do_reset();
        cur_lat = 3;
        step(0, 1, 1, 0, '0);
        step(0, 1, 1, 0, '0);
        step(0, 1, 1, 1, 32'h103);
        step(0, 0, 1, 0, '0);
        check("redir_addr", imem_req_addr, 32'h100);
        check("redir_drain_req", {31'd0, imem_req_valid}, 32'd0);
        cur_lat = 0;
        acc_seen = 0;
        for (int i = 0; i < 12 && !acc_seen; i++) step(0, 1, 1, 0, '0);
        check("redir_resume_seen", {31'd0, acc_seen}, 32'd1);
        check("redir_resume_addr", last_acc_addr, 32'h100);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, '0);

        // Redirect + response + pop together, then redirect while draining
        do_reset();
        cur_lat = 0;
        step(0, 1, 1, 0, '0);
        step(0, 1, 1, 0, '0);
        step(0, 1, 1, 1, 32'h200);
        cur_lat = 3;
        step(0, 1, 1, 0, '0);
        check("flush_dec_valid", {31'd0, dec_valid}, 32'd0);
        check("flush_req_addr", imem_req_addr, 32'h200);
        step(0, 1, 1, 0, '0);
        step(0, 1, 1, 1, 32'h300);
        step(0, 1, 1, 1, 32'h400);
        cur_lat = 0;
        acc_seen = 0;
        for (int i = 0; i < 12 && !acc_seen; i++) step(0, 1, 1, 0, '0);
        check("redrain_resume_addr", last_acc_addr, 32'h400);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, '0);

        // Randomized traffic with one mid-run reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cur_lat = int'($urandom_range(0, 3));
            if (i == 1500 || i == 1501)
                step(1, 0, 0, 0, '0);
            else
                step(0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                     ($urandom % 20) == 0, $urandom & 32'h3ff);
        end

        // Drain everything still owed to decode
        cur_lat = 0;
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, '0);
        check("final_exp_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
